// File: rtl/simd_wb_latency_align.sv
// ---------------------------------------------------------------------------
// simd_wb_latency_align
//
// Aligns SIMD write-back requests to a per-opcode latency. Each accepted
// request is dropped into a shift chain of slots at the position that makes
// it reach the output exactly L cycles later; L == 0 bypasses straight to the
// outputs in the same cycle. The latency comes from a small writable table
// indexed by the effective opcode, where the LOOP encoding {0x0,0xF} reuses
// the last non-LOOP instruction seen.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (accepted when both high)
//   opcode, fn            instruction of the offered request
//   buf_wr_req_in/addr_in write-back payload of the offered request
//   cfg_we/opcode/latency latency-table write port (idle-only)
//   opcode_out, fn_out    effective instruction after LOOP substitution
//   out_valid, buf_wr_req_out, buf_wr_addr_out   aligned write-back
//   busy                  any slot occupied
//   cfg_err               sticky: ignored or saturated table write
// ---------------------------------------------------------------------------
module simd_wb_latency_align #(
    parameter int OPCODE_BITS   = 4,
    parameter int FUNCTION_BITS = 4,
    parameter int REQ_BITS      = 6,
    parameter int ADDR_BITS     = 32,
    parameter int MAX_STAGES    = 16,
    parameter int LAT_BITS      = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_BITS-1:0]   opcode,
    input  logic [FUNCTION_BITS-1:0] fn,
    input  logic [REQ_BITS-1:0]      buf_wr_req_in,
    input  logic [ADDR_BITS-1:0]     buf_wr_addr_in,
    input  logic                     cfg_we,
    input  logic [OPCODE_BITS-1:0]   cfg_opcode,
    input  logic [LAT_BITS-1:0]      cfg_latency,
    output logic [OPCODE_BITS-1:0]   opcode_out,
    output logic [FUNCTION_BITS-1:0] fn_out,
    output logic                     out_valid,
    output logic [REQ_BITS-1:0]      buf_wr_req_out,
    output logic [ADDR_BITS-1:0]     buf_wr_addr_out,
    output logic                     busy,
    output logic                     cfg_err
);

    localparam int TABLE_SIZE = 1 << OPCODE_BITS;
    localparam logic [OPCODE_BITS-1:0]   LOOP_OPCODE = '0;
    localparam logic [FUNCTION_BITS-1:0] LOOP_FN     = FUNCTION_BITS'(15);
    localparam logic [LAT_BITS-1:0]      MAX_LAT     = LAT_BITS'(MAX_STAGES);
    // Opcode 0x1 powers up at latency 8 (clamped if the chain is shorter).
    localparam logic [LAT_BITS-1:0]      OP1_RESET_LAT =
        (MAX_STAGES < 8) ? MAX_LAT : LAT_BITS'(8);

    // Last non-LOOP instruction seen with in_valid high.
    logic [OPCODE_BITS-1:0]   last_opcode;
    logic [FUNCTION_BITS-1:0] last_fn;

    logic [LAT_BITS-1:0] lat_table [TABLE_SIZE];
    logic                cfg_err_q;

    // Slot k reaches the output k-1 cycles from now; slot 1 is the output.
    logic [MAX_STAGES:1] s_valid;
    logic [REQ_BITS-1:0]  s_req  [1:MAX_STAGES];
    logic [ADDR_BITS-1:0] s_addr [1:MAX_STAGES];

    logic                     is_loop;
    logic [OPCODE_BITS-1:0]   eff_opcode;
    logic [FUNCTION_BITS-1:0] eff_fn;
    logic [LAT_BITS-1:0]      lat;
    logic                     target_taken;
    logic                     accept;
    logic                     bypass;

    // ---------------------------------------------------------------------
    // Effective instruction and its latency
    // ---------------------------------------------------------------------
    always_comb begin
        is_loop    = (opcode == LOOP_OPCODE) && (fn == LOOP_FN);
        eff_opcode = is_loop ? last_opcode : opcode;
        eff_fn     = is_loop ? last_fn     : fn;
        lat        = lat_table[eff_opcode];
    end

    // The slot a request of latency L lands in is S[L] after the shift, so it
    // collides with whatever currently sits in S[L+1]. For L == 0 the
    // collision is with the slot being emitted right now.
    always_comb begin
        // NOTE: default assigned first so every path drives the variable and
        // no latch is inferred.
        target_taken = 1'b0;
        if (lat == '0) begin
            target_taken = s_valid[1];
        end
        for (int k = 1; k < MAX_STAGES; k++) begin
            if (lat == LAT_BITS'(k)) begin
                target_taken = s_valid[k+1];
            end
        end
    end

    assign in_ready = !reset && !target_taken;
    assign accept   = in_valid && in_ready;
    assign bypass   = accept && (lat == '0);

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        out_valid       = 1'b0;
        buf_wr_req_out  = '0;
        buf_wr_addr_out = '0;
        if (bypass) begin
            out_valid       = 1'b1;
            buf_wr_req_out  = buf_wr_req_in;
            buf_wr_addr_out = buf_wr_addr_in;
        end else if (!reset && s_valid[1]) begin
            out_valid       = 1'b1;
            buf_wr_req_out  = s_req[1];
            buf_wr_addr_out = s_addr[1];
        end
    end

    assign opcode_out = reset ? '0 : eff_opcode;
    assign fn_out     = reset ? '0 : eff_fn;
    assign busy       = !reset && (|s_valid);
    assign cfg_err    = !reset && cfg_err_q;

    // ---------------------------------------------------------------------
    // Slot chain: valid bits
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s_valid <= '0;
        end else begin
            // NOTE: non-blocking so every slot takes its neighbour's pre-edge
            // value; the later load below overrides the shift for slot L.
            for (int k = 1; k < MAX_STAGES; k++) begin
                s_valid[k] <= s_valid[k+1];
            end
            s_valid[MAX_STAGES] <= 1'b0;
            for (int k = 1; k <= MAX_STAGES; k++) begin
                if (accept && lat == LAT_BITS'(k)) begin
                    s_valid[k] <= 1'b1;
                end
            end
        end
    end

    // NOTE: payload is qualified by s_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int k = 1; k < MAX_STAGES; k++) begin
            s_req[k]  <= s_req[k+1];
            s_addr[k] <= s_addr[k+1];
        end
        for (int k = 1; k <= MAX_STAGES; k++) begin
            if (accept && lat == LAT_BITS'(k)) begin
                s_req[k]  <= buf_wr_req_in;
                s_addr[k] <= buf_wr_addr_in;
            end
        end
    end

    // ---------------------------------------------------------------------
    // LOOP history
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            last_opcode <= '0;
            last_fn     <= '0;
        end else if (in_valid && !is_loop) begin
            last_opcode <= opcode;
            last_fn     <= fn;
        end
    end

    // ---------------------------------------------------------------------
    // Latency table and config error
    // ---------------------------------------------------------------------
    // Writes are only safe while nothing is in flight or being offered, since
    // a changed latency could otherwise reorder or collide with live slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the table is reset because its entries have defined
            // power-up latencies that requests depend on immediately.
            for (int k = 0; k < TABLE_SIZE; k++) begin
                lat_table[k] <= (k == 1) ? OP1_RESET_LAT : '0;
            end
            cfg_err_q <= 1'b0;
        end else if (cfg_we) begin
            if (busy || in_valid) begin
                cfg_err_q <= 1'b1;
            end else if (cfg_latency > MAX_LAT) begin
                lat_table[cfg_opcode] <= MAX_LAT;
                cfg_err_q             <= 1'b1;
            end else begin
                lat_table[cfg_opcode] <= cfg_latency;
            end
        end
    end

endmodule

// File: doc/simd_wb_latency_align.md
SIMD_WB_LATENCY_ALIGN -- requirements
Module: simd_wb_latency_align

Interface
REQ-001 SHALL have parameter OPCODE_BITS, default 4, instruction opcode width.
REQ-002 SHALL have parameter FUNCTION_BITS, default 4, function-code width.
REQ-003 SHALL have parameter REQ_BITS, default 6, buffer write-request vector width.
REQ-004 SHALL have parameter ADDR_BITS, default 32, buffer write-address width.
REQ-005 SHALL have parameter MAX_STAGES, default 16, deepest supported latency, range 1..31.
REQ-006 SHALL have parameter LAT_BITS, default 5, latency field width, wide enough to hold MAX_STAGES.
REQ-007 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-008 SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-009 SHALL have port in_valid, input, 1, write-back request offered.
REQ-010 SHALL have port in_ready, output, 1, request accepted this cycle when high with in_valid.
REQ-011 SHALL have port opcode, input, OPCODE_BITS, opcode of offered request.
REQ-012 SHALL have port fn, input, FUNCTION_BITS, function code of offered request.
REQ-013 SHALL have port buf_wr_req_in, input, REQ_BITS, write-request vector.
REQ-014 SHALL have port buf_wr_addr_in, input, ADDR_BITS, write address.
REQ-015 SHALL have ports cfg_we (1), cfg_opcode (OPCODE_BITS), cfg_latency (LAT_BITS), inputs, latency-table write port.
REQ-016 SHALL have ports opcode_out (OPCODE_BITS) and fn_out (FUNCTION_BITS), outputs, effective instruction after loop substitution.
REQ-017 SHALL have ports out_valid (1), buf_wr_req_out (REQ_BITS), buf_wr_addr_out (ADDR_BITS), outputs, aligned write-back.
REQ-018 SHALL have ports busy (1), cfg_err (1), outputs, pipeline-occupied flag and sticky config error.

Function
REQ-019 SHALL treat {opcode,fn} == {0x0,0xF} as LOOP; effective {opcode,fn} is then the last non-LOOP pair seen while in_valid was high, else the inputs themselves.
REQ-020 SHALL drive opcode_out/fn_out combinationally with the effective pair.
REQ-021 SHALL hold a latency table of 2^OPCODE_BITS entries indexed by effective opcode; reset values: all 0, except entry 0x1 = 8.
REQ-022 SHALL write cfg_latency into entry cfg_opcode on cfg_we only when busy is low and in_valid is low; cfg_we otherwise SHALL be ignored and SHALL set cfg_err.
REQ-023 SHALL saturate a written latency above MAX_STAGES to MAX_STAGES and set cfg_err; cfg_err clears only on reset.
REQ-024 SHALL keep slots S[1..MAX_STAGES] (valid, req, addr); each edge S[k] <= S[k+1], S[MAX_STAGES] <= empty, unless loaded per REQ-025.
REQ-025 SHALL, on acceptance with latency L >= 1, load S[L] at that edge, so the request appears on outputs exactly L cycles after acceptance.
REQ-026 SHALL present S[1] on out_valid/buf_wr_req_out/buf_wr_addr_out; zeros when S[1] empty.
REQ-027 SHALL, for L == 0, bypass combinationally: outputs = inputs in the acceptance cycle.
REQ-028 SHALL drive in_ready low when the target is taken: L == 0 with S[1] valid; 1 <= L < MAX_STAGES with S[L+1] valid; L == MAX_STAGES always free.
REQ-029 SHALL preserve output order per the latency schedule; a shorter-latency request may overtake a longer one.
REQ-030 SHALL drive busy = OR of all slot valid bits.
REQ-031 SHALL accept one request per cycle at most; no internal buffering beyond the slots.

Reset
REQ-032 SHALL, on reset, clear all slot valid bits, set last non-LOOP pair to {0,0}, and restore the latency table to reset values.
REQ-033 SHALL, during reset cycles, drive out_valid 0, in_ready 0, busy 0, cfg_err 0, data outputs 0.
REQ-034 SHALL discard in-flight requests on reset mid-operation; nothing is emitted after release.

Verification
REQ-035 SHALL check: opcode 0x0/fn 0x1, addr 0x10 accepted at t -> out_valid with addr 0x10 at t, combinational.
REQ-036 SHALL check: opcode 0x1/fn 0x8, addr 0x20 accepted at t -> out_valid, addr 0x20 at t+8 only.
REQ-037 SHALL check: 0x1/0x8 then LOOP for 3 cycles -> opcode_out 0x1, fn_out 0x8 throughout; outputs at t+8..t+11 in order.
REQ-038 SHALL check: cfg latency 3 for opcode 0x2; latency-8 request at t, latency-3 at t+5 -> in_ready low at t+5 (S[4] valid), request held and accepted at t+6, exits t+9.
REQ-039 SHALL check: cfg_we while busy -> table unchanged, cfg_err 1; cfg_latency 31 with MAX_STAGES 16 -> stored 16, cfg_err 1.
REQ-040 SHALL check: reset asserted with 4 requests in flight -> busy 0 next cycle, no out_valid after release.
